// File: rtl/fetch_queue_if.sv
// Fetch queue interface: system-bus request/response handshake plus the decoder-side
// window, consume and redirect signals.
//   master : fetch_queue side (drives requests, window, respack, error flag)
//   slave  : bus / decoder side (drives acks, response beats, redirect, consume)
interface fetch_queue_if #(
  parameter int unsigned WIN_BYTES = 15,
  parameter int unsigned TAG_W     = 13
);
  localparam int unsigned WvW = $clog2(WIN_BYTES + 1);

  // System bus
  logic                   reqcyc;
  logic [63:0]            req;
  logic [TAG_W-1:0]       reqtag;
  logic                   reqack;
  logic                   respcyc;
  logic [63:0]            resp;
  logic                   respack;

  // Decoder
  logic                   redirect;
  logic [63:0]            redirect_rip;
  logic [WIN_BYTES*8-1:0] win_bytes;
  logic [WvW-1:0]         win_valid;
  logic [63:0]            win_rip;
  logic [WvW-1:0]         consume;
  logic                   err_overconsume;

  modport master (
    output reqcyc, req, reqtag, respack, win_bytes, win_valid, win_rip, err_overconsume,
    input  reqack, respcyc, resp, redirect, redirect_rip, consume
  );

  modport slave (
    input  reqcyc, req, reqtag, respack, win_bytes, win_valid, win_rip, err_overconsume,
    output reqack, respcyc, resp, redirect, redirect_rip, consume
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch queue. Requests cache lines from the system bus, packs the returned
// 64-bit beats into a circular byte buffer and presents a byte-aligned decode window.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : fetch_queue_if.master (request/response handshake, window, consume,
//                redirect, sticky over-consume error)
// Optional feature (macro FETCH_PERF_CNT_EN): adds perf_lines, perf_starve, perf_flush
// 32-bit wrapping event counters.
module fetch_queue #(
  parameter int unsigned     BUF_BYTES  = 128,
  parameter int unsigned     LINE_BYTES = 64,
  parameter int unsigned     BEAT_BYTES = 8,
  parameter int unsigned     WIN_BYTES  = 15,
  parameter int unsigned     TAG_W      = 13,
  parameter logic [TAG_W-1:0] READ_TAG  = 13'h1100
) (
  input  logic         clk,
  input  logic         reset,
  fetch_queue_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]  perf_lines,
  output logic [31:0]  perf_starve,
  output logic [31:0]  perf_flush
`endif
);

  localparam int unsigned PTR_W  = $clog2(BUF_BYTES);
  localparam int unsigned CNT_W  = $clog2(BUF_BYTES + 1);
  localparam int unsigned LOFF_W = $clog2(LINE_BYTES);
  localparam int unsigned NBEATS = LINE_BYTES / BEAT_BYTES;
  localparam int unsigned BCNT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned WV_W   = $clog2(WIN_BYTES + 1);
  localparam int unsigned SKIP_W = $clog2(BEAT_BYTES + 1);

  typedef enum logic [1:0] {StIdle, StWait, StActive, StDrain} state_e;

  state_e            state_q, state_d;
  logic [63:0]       fetch_addr_q, fetch_addr_d;
  logic [63:0]       req_q, req_d;
  logic [63:0]       win_rip_q, win_rip_d;
  logic [TAG_W-1:0]  reqtag_q, reqtag_d;
  logic              reqcyc_q, reqcyc_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LOFF_W-1:0] drop_q, drop_d;
  logic [BCNT_W-1:0] beat_q, beat_d;
  logic [7:0]        buf_q [BUF_BYTES];

  logic [CNT_W-1:0]  free_bytes, written;
  logic [WV_W-1:0]   win_valid, cons_eff;
  logic              overconsume, last_beat, wr_en;
  logic [SKIP_W-1:0] skip;

  // Shared datapath terms
  always_comb begin
    free_bytes  = CNT_W'(BUF_BYTES) - count_q;
    win_valid   = (count_q < CNT_W'(WIN_BYTES)) ? WV_W'(count_q) : WV_W'(WIN_BYTES);
    overconsume = bus.consume > win_valid;
    cons_eff    = overconsume ? win_valid : bus.consume;
    last_beat   = beat_q == BCNT_W'(NBEATS - 1);
    // A beat arriving together with a redirect belongs to the stale stream: count it, drop it.
    wr_en       = bus.respcyc && !bus.redirect && (state_q == StWait || state_q == StActive);
    // Leading bytes before the fetch address inside the first line are discarded.
    skip        = (drop_q >= LOFF_W'(BEAT_BYTES)) ? SKIP_W'(BEAT_BYTES) : SKIP_W'(drop_q);
    written     = wr_en ? (CNT_W'(BEAT_BYTES) - CNT_W'(skip)) : '0;
  end

  // State register and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      fetch_addr_q <= '0;
      req_q        <= '0;
      win_rip_q    <= '0;
      reqtag_q     <= '0;
      reqcyc_q     <= 1'b0;
      err_q        <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      drop_q       <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      req_q        <= req_d;
      win_rip_q    <= win_rip_d;
      reqtag_q     <= reqtag_d;
      reqcyc_q     <= reqcyc_d;
      err_q        <= err_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      drop_q       <= drop_d;
      beat_q       <= beat_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        // An ack that coincides with a redirect still owes us a full line of beats.
        if (reqcyc_q && bus.reqack) state_d = bus.redirect ? StDrain : StWait;
      end
      StWait, StActive: begin
        if (bus.respcyc) begin
          if (last_beat)         state_d = StIdle;
          else if (bus.redirect) state_d = StDrain;
          else                   state_d = StActive;
        end else if (bus.redirect) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (bus.respcyc && last_beat) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values and registered request outputs
  always_comb begin
    fetch_addr_d = fetch_addr_q;
    req_d        = req_q;
    reqtag_d     = reqtag_q;
    win_rip_d    = win_rip_q;
    err_d        = err_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    drop_d       = drop_q;
    beat_d       = beat_q;

    if (bus.respcyc && state_q != StIdle) beat_d = last_beat ? '0 : beat_q + 1'b1;

    if (bus.redirect) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      win_rip_d    = bus.redirect_rip;
      fetch_addr_d = bus.redirect_rip;
      drop_d       = bus.redirect_rip[LOFF_W-1:0];
    end else begin
      if (wr_en) begin
        tail_d = tail_q + PTR_W'(written);
        drop_d = drop_q - LOFF_W'(skip);
        if (last_beat) fetch_addr_d = fetch_addr_q + 64'(LINE_BYTES);
      end
      head_d    = head_q + PTR_W'(cons_eff);
      win_rip_d = win_rip_q + 64'(cons_eff);
      count_d   = count_q + written - CNT_W'(cons_eff);
      if (overconsume) err_d = 1'b1;
    end

    reqcyc_d = (state_q == StIdle) && !bus.redirect && !bus.reqack &&
               (free_bytes >= CNT_W'(LINE_BYTES));
    if (reqcyc_d) begin
      req_d    = {fetch_addr_q[63:LOFF_W], {LOFF_W{1'b0}}};
      reqtag_d = READ_TAG;
    end
  end

  // Byte buffer: no reset needed, bytes are only visible below count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BEAT_BYTES; i++) begin
        if (SKIP_W'(i) >= skip) begin
          buf_q[tail_q + PTR_W'(i) - PTR_W'(skip)] <= bus.resp[8*i +: 8];
        end
      end
    end
  end

  // Decode window wraps naturally through the PTR_W-bit index.
  always_comb begin
    bus.win_bytes = '0;
    for (int i = 0; i < WIN_BYTES; i++) begin
      bus.win_bytes[8*i +: 8] = buf_q[head_q + PTR_W'(i)];
    end
  end

  assign bus.reqcyc          = reqcyc_q;
  assign bus.req             = req_q;
  assign bus.reqtag          = reqtag_q;
  assign bus.respack         = bus.respcyc;
  assign bus.win_valid       = win_valid;
  assign bus.win_rip         = win_rip_q;
  assign bus.err_overconsume = err_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_lines_q, perf_starve_q, perf_flush_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lines_q  <= '0;
      perf_starve_q <= '0;
      perf_flush_q  <= '0;
    end else begin
      if (wr_en && last_beat) perf_lines_q <= perf_lines_q + 32'd1;
      if (!bus.redirect && win_valid < WV_W'(WIN_BYTES)) perf_starve_q <= perf_starve_q + 32'd1;
      if (bus.redirect) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_lines  = perf_lines_q;
  assign perf_starve = perf_starve_q;
  assign perf_flush  = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue. Beat data carries the low address byte
// (optionally XORed with address bits [15:8] to tell lines of different pages apart).
module tb_fetch_queue;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_queue_if #(.WIN_BYTES(15), .TAG_W(13)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_lines, perf_starve, perf_flush;
`endif

  fetch_queue #(
    .BUF_BYTES(128), .LINE_BYTES(64), .BEAT_BYTES(8), .WIN_BYTES(15), .TAG_W(13),
    .READ_TAG(13'h1100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_lines(perf_lines),
    .perf_starve(perf_starve),
    .perf_flush(perf_flush)
`endif
  );

  int checks;
  int errors;
  bit use_hi;

  function automatic logic [7:0] byte_of(input logic [63:0] a);
    return use_hi ? (a[7:0] ^ a[15:8]) : a[7:0];
  endfunction

  function automatic logic [63:0] beat_of(input logic [63:0] a);
    logic [63:0] d;
    for (int i = 0; i < 8; i++) d[8*i +: 8] = byte_of(a + 64'(i));
    return d;
  endfunction

  task automatic send_beat(input logic [63:0] a);
    bus.respcyc = 1'b1;
    bus.resp    = beat_of(a);
    @(negedge clk);
    bus.respcyc = 1'b0;
  endtask

  task automatic do_consume(input logic [3:0] n);
    bus.consume = n;
    @(negedge clk);
    bus.consume = '0;
  endtask

  task automatic do_redirect(input logic [63:0] rip);
    bus.redirect     = 1'b1;
    bus.redirect_rip = rip;
    @(negedge clk);
    bus.redirect     = 1'b0;
  endtask

  // Waits (bounded) for a request, checks address/tag, acks it for one cycle.
  task automatic request(input logic [63:0] addr);
    int n = 0;
    while (bus.reqcyc !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.reqcyc !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout: reqcyc=%b required 1 (expected req %h)", bus.reqcyc, addr);
    end else begin
      checks++;
      if (bus.req !== addr) begin
        errors++; $display("FAIL req_addr: got %h want %h", bus.req, addr);
      end
      checks++;
      if (bus.reqtag !== 13'h1100) begin
        errors++; $display("FAIL req_tag: got %h want 1100", bus.reqtag);
      end
      bus.reqack = 1'b1;
      @(negedge clk);
      bus.reqack = 1'b0;
      checks++;
      if (bus.reqcyc !== 1'b0) begin
        errors++; $display("FAIL req_drop: reqcyc=%b want 0 after ack", bus.reqcyc);
      end
    end
  endtask

  task automatic release_reset(input logic [63:0] rip);
    bus.redirect     = 1'b1;
    bus.redirect_rip = rip;
    reset            = 1'b0;
    @(negedge clk);
    bus.redirect     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.reqcyc, bus.req, bus.reqtag, bus.win_rip, bus.win_valid, bus.err_overconsume}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: reqcyc=%b req=%h tag=%h rip=%h wv=%0d err=%b want all 0",
               bus.reqcyc, bus.req, bus.reqtag, bus.win_rip, bus.win_valid,
               bus.err_overconsume);
    end
    release_reset(64'h1000);
    checks++;
    if (bus.win_rip !== 64'h1000 || bus.reqcyc !== 1'b0) begin
      errors++;
      $display("FAIL reset_exit: rip=%h reqcyc=%b want 1000/0", bus.win_rip, bus.reqcyc);
    end
  endtask

  task automatic test_fill();
    bit stray;
    request(64'h1000);
    for (int k = 0; k < 8; k++) send_beat(64'h1000 + 64'(8 * k));
    checks++;
    if (bus.win_valid !== 4'd15 || bus.win_rip !== 64'h1000) begin
      errors++;
      $display("FAIL fill_window: wv=%0d rip=%h want 15/1000", bus.win_valid, bus.win_rip);
    end
    checks++;
    if (bus.win_bytes[7:0] !== 8'h00 || bus.win_bytes[119:112] !== 8'h0e) begin
      errors++;
      $display("FAIL fill_bytes: b0=%h b14=%h want 00/0e", bus.win_bytes[7:0],
               bus.win_bytes[119:112]);
    end
    request(64'h1040);
    for (int k = 0; k < 8; k++) send_beat(64'h1040 + 64'(8 * k));
    stray = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.reqcyc !== 1'b0) stray = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (stray) begin
      errors++; $display("FAIL fill_no_third_req: reqcyc seen 1 want 0 while full");
    end
  endtask

  task automatic test_unaligned();
    do_redirect(64'h1013);
    checks++;
    if (bus.win_valid !== 4'd0 || bus.win_rip !== 64'h1013) begin
      errors++;
      $display("FAIL unal_flush: wv=%0d rip=%h want 0/1013", bus.win_valid, bus.win_rip);
    end
    request(64'h1000);
    send_beat(64'h1000);
    send_beat(64'h1008);
    checks++;
    if (bus.win_valid !== 4'd0) begin
      errors++; $display("FAIL unal_drop: wv=%0d want 0", bus.win_valid);
    end
    send_beat(64'h1010);
    checks++;
    if (bus.win_valid !== 4'd5 || bus.win_bytes[7:0] !== 8'h13 ||
        bus.win_bytes[39:32] !== 8'h17) begin
      errors++;
      $display("FAIL unal_partial: wv=%0d b0=%h b4=%h want 5/13/17", bus.win_valid,
               bus.win_bytes[7:0], bus.win_bytes[39:32]);
    end
    send_beat(64'h1018);
    checks++;
    if (bus.win_valid !== 4'd13) begin
      errors++; $display("FAIL unal_wv13: wv=%0d want 13", bus.win_valid);
    end
    for (int k = 4; k < 8; k++) send_beat(64'h1000 + 64'(8 * k));
    // 45 bytes: two full windows, then exactly 15 remain, then empty.
    do_consume(4'd15);
    checks++;
    if (bus.win_rip !== 64'h1022 || bus.win_bytes[7:0] !== 8'h22 || bus.win_valid !== 4'd15)
    begin
      errors++;
      $display("FAIL unal_c1: rip=%h b0=%h wv=%0d want 1022/22/15", bus.win_rip,
               bus.win_bytes[7:0], bus.win_valid);
    end
    do_consume(4'd15);
    do_consume(4'd15);
    checks++;
    if (bus.win_valid !== 4'd0 || bus.win_rip !== 64'h1040 || bus.err_overconsume !== 1'b0)
    begin
      errors++;
      $display("FAIL unal_count45: wv=%0d rip=%h err=%b want 0/1040/0", bus.win_valid,
               bus.win_rip, bus.err_overconsume);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp;
    do_redirect(64'h1000);
    request(64'h1000);
    for (int k = 0; k < 8; k++) send_beat(64'h1000 + 64'(8 * k));
    request(64'h1040);
    for (int k = 0; k < 8; k++) send_beat(64'h1040 + 64'(8 * k));
    for (int k = 0; k < 8; k++) begin
      do_consume(4'd15);
      exp = 64'h1000 + 64'(15 * (k + 1));
      checks++;
      if (bus.win_rip !== exp || bus.win_bytes[7:0] !== exp[7:0]) begin
        errors++;
        $display("FAIL wrap_step%0d: rip=%h b0=%h want %h/%h", k, bus.win_rip,
                 bus.win_bytes[7:0], exp, exp[7:0]);
      end
    end
    request(64'h1080);
    for (int k = 0; k < 8; k++) send_beat(64'h1080 + 64'(8 * k));
    checks++;
    if (bus.win_valid !== 4'd15 || bus.win_bytes[7:0] !== 8'h78 ||
        bus.win_bytes[63:56] !== 8'h7f || bus.win_bytes[71:64] !== 8'h80 ||
        bus.win_bytes[79:72] !== 8'h81) begin
      errors++;
      $display("FAIL wrap_cross: wv=%0d b0=%h b7=%h b8=%h b9=%h want 15/78/7f/80/81",
               bus.win_valid, bus.win_bytes[7:0], bus.win_bytes[63:56],
               bus.win_bytes[71:64], bus.win_bytes[79:72]);
    end
    do_consume(4'd15);
    checks++;
    if (bus.win_rip !== 64'h1087 || bus.win_bytes[7:0] !== 8'h87) begin
      errors++;
      $display("FAIL wrap_after: rip=%h b0=%h want 1087/87", bus.win_rip, bus.win_bytes[7:0]);
    end
  endtask

  task automatic test_redirect_drain();
    bit bad;
    use_hi = 1'b1;
    do_redirect(64'h1000);
    request(64'h1000);
    for (int k = 0; k < 3; k++) send_beat(64'h1000 + 64'(8 * k));
    bus.redirect     = 1'b1;
    bus.redirect_rip = 64'h2000;
    send_beat(64'h1018);
    bus.redirect     = 1'b0;
    checks++;
    if (bus.win_valid !== 4'd0 || bus.win_rip !== 64'h2000) begin
      errors++;
      $display("FAIL drain_flush: wv=%0d rip=%h want 0/2000", bus.win_valid, bus.win_rip);
    end
    bad = 1'b0;
    for (int k = 4; k < 8; k++) begin
      bus.respcyc = 1'b1;
      bus.resp    = beat_of(64'h1000 + 64'(8 * k));
      #1;
      if (bus.respack !== 1'b1 || bus.reqcyc !== 1'b0 || bus.win_valid !== 4'd0) bad = 1'b1;
      @(negedge clk);
      bus.respcyc = 1'b0;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL drain_beats: respack/reqcyc/wv wrong, want 1/0/0 while draining");
    end
    request(64'h2000);
    for (int k = 0; k < 8; k++) send_beat(64'h2000 + 64'(8 * k));
    checks++;
    if (bus.win_valid !== 4'd15 || bus.win_rip !== 64'h2000 || bus.win_bytes[7:0] !== 8'h20 ||
        bus.win_bytes[15:8] !== 8'h21) begin
      errors++;
      $display("FAIL drain_newline: wv=%0d rip=%h b0=%h b1=%h want 15/2000/20/21",
               bus.win_valid, bus.win_rip, bus.win_bytes[7:0], bus.win_bytes[15:8]);
    end
    use_hi = 1'b0;
  endtask

  task automatic test_overconsume_async_reset();
    do_redirect(64'h103d);
    request(64'h1000);
    for (int k = 0; k < 8; k++) send_beat(64'h1000 + 64'(8 * k));
    checks++;
    if (bus.win_valid !== 4'd3 || bus.win_bytes[7:0] !== 8'h3d) begin
      errors++;
      $display("FAIL over_setup: wv=%0d b0=%h want 3/3d", bus.win_valid, bus.win_bytes[7:0]);
    end
    do_consume(4'd5);
    checks++;
    if (bus.win_valid !== 4'd0 || bus.win_rip !== 64'h1040 || bus.err_overconsume !== 1'b1)
    begin
      errors++;
      $display("FAIL over_clamp: wv=%0d rip=%h err=%b want 0/1040/1", bus.win_valid,
               bus.win_rip, bus.err_overconsume);
    end
    request(64'h1040);
    for (int k = 0; k < 3; k++) send_beat(64'h1040 + 64'(8 * k));
    checks++;
    if (bus.err_overconsume !== 1'b1 || bus.win_valid !== 4'd15) begin
      errors++;
      $display("FAIL over_sticky: err=%b wv=%0d want 1/15", bus.err_overconsume,
               bus.win_valid);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus.reqcyc, bus.req, bus.reqtag, bus.win_rip, bus.win_valid, bus.err_overconsume}
        !== '0) begin
      errors++;
      $display("FAIL async_reset: reqcyc=%b req=%h tag=%h rip=%h wv=%0d err=%b want all 0",
               bus.reqcyc, bus.req, bus.reqtag, bus.win_rip, bus.win_valid,
               bus.err_overconsume);
    end
    @(negedge clk);
    release_reset(64'h1000);
  endtask

  task automatic test_redirect_collide();
    use_hi = 1'b1;
    request(64'h1000);
    for (int k = 0; k < 8; k++) send_beat(64'h1000 + 64'(8 * k));
    request(64'h1040);
    bus.redirect     = 1'b1;
    bus.redirect_rip = 64'h3000;
    bus.consume      = 4'd4;
    send_beat(64'h1040);
    bus.redirect     = 1'b0;
    bus.consume      = '0;
    checks++;
    if (bus.win_rip !== 64'h3000 || bus.win_valid !== 4'd0 || bus.err_overconsume !== 1'b0)
    begin
      errors++;
      $display("FAIL collide: rip=%h wv=%0d err=%b want 3000/0/0", bus.win_rip,
               bus.win_valid, bus.err_overconsume);
    end
    for (int k = 1; k < 8; k++) send_beat(64'h1040 + 64'(8 * k));
    checks++;
    if (bus.win_valid !== 4'd0) begin
      errors++; $display("FAIL collide_drain: wv=%0d want 0", bus.win_valid);
    end
    request(64'h3000);
    for (int k = 0; k < 8; k++) send_beat(64'h3000 + 64'(8 * k));
    checks++;
    if (bus.win_bytes[7:0] !== 8'h30 || bus.win_valid !== 4'd15) begin
      errors++;
      $display("FAIL collide_newline: b0=%h wv=%0d want 30/15", bus.win_bytes[7:0],
               bus.win_valid);
    end
    use_hi = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks           = 0;
    errors           = 0;
    use_hi           = 1'b0;
    reset            = 1'b1;
    bus.reqack       = 1'b0;
    bus.respcyc      = 1'b0;
    bus.resp         = '0;
    bus.redirect     = 1'b0;
    bus.redirect_rip = '0;
    bus.consume      = '0;
    test_reset();
    test_fill();
    test_unaligned();
    test_wrap();
    test_redirect_drain();
    test_overconsume_async_reset();
    test_redirect_collide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
